// File: rtl/apb4_slave_mem.sv
// APB4 completer: word-addressed register memory with byte strobes, fixed wait states and error responses.
// Optional compile-time feature: APB4_SLAVE_MEM_PROT_CHECK_EN (non-secure writes to the upper half are rejected).
module apb4_slave_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [3:0]            PSTRB,
    input  logic [2:0]            PPROT,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  write_q, write_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            strb_q, strb_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [MEM_DEPTH];

    logic [IDX_W-1:0]      setup_idx;
    logic                  setup_err;
    logic                  unused_prot;

    assign setup_idx   = PADDR[IDX_W+1:2];
    assign unused_prot = ^PPROT;

    // Error is decided once, from the setup-phase inputs, and carried through the access phase.
    always_comb begin
        setup_err = (PADDR[1:0] != 2'b00) || ({1'b0, PADDR} >= ADDR_LIMIT);
`ifdef APB4_SLAVE_MEM_PROT_CHECK_EN
        if (PWRITE && PPROT[1] && setup_idx[IDX_W-1]) begin
            setup_err = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        err_d     = err_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        mem_d     = mem_q;

        if (state_q == ST_IDLE) begin
            if (PSEL && !PENABLE) begin
                state_d = ST_ACCESS;
                cnt_d   = 4'(WAIT_STATES);
                idx_d   = setup_idx;
                write_d = PWRITE;
                wdata_d = PWDATA;
                strb_d  = PSTRB;
                err_d   = setup_err;
                // With no wait states the first access cycle already completes.
                if (WAIT_STATES == 0) begin
                    pready_d  = 1'b1;
                    pslverr_d = setup_err;
                    prdata_d  = (PWRITE || setup_err) ? '0 : mem_q[setup_idx];
                end
            end
        end else begin
            if (!PSEL) begin
                state_d   = ST_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end else if (pready_q) begin
                if (PENABLE) begin
                    if (write_q && !err_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (strb_q[b]) begin
                                mem_d[idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                            end
                        end
                    end
                    state_d   = ST_IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end else begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                    prdata_d  = (write_q || err_q) ? '0 : mem_q[idx_q];
                end
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            err_q     <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            err_q     <= err_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            mem_q     <= mem_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb4_slave_mem.sv
// Bench for apb4_slave_mem: one instance with no wait states and one with three, a constant vector table,
// directed abort/reset sequences and randomized transfers against an array-based memory model.
module tb_apb4_slave_mem;

    localparam int N_DUT = 2;
`ifdef APB4_SLAVE_MEM_PROT_CHECK_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    logic        clk;
    logic        presetn [N_DUT];
    logic        psel    [N_DUT];
    logic        penable [N_DUT];
    logic        pwrite  [N_DUT];
    logic [31:0] paddr   [N_DUT];
    logic [31:0] pwdata  [N_DUT];
    logic [3:0]  pstrb   [N_DUT];
    logic [2:0]  pprot   [N_DUT];
    logic [31:0] prdata  [N_DUT];
    logic        pready  [N_DUT];
    logic        pslverr [N_DUT];

    logic [31:0] model_mem [N_DUT][16];
    int          num_compared;
    int          num_failed;
    vec_t        vectors [$];

    apb4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(0)) u_dut0 (
        .PCLK(clk), .PRESETn(presetn[0]), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PPROT(pprot[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0])
    );

    apb4_slave_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(16), .WAIT_STATES(3)) u_dut3 (
        .PCLK(clk), .PRESETn(presetn[1]), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PPROT(pprot[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waitOf(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_failed++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // One complete transfer starting in the current cycle; inputs are scrambled during access.
    task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [2:0] prot,
                                 output logic [31:0] rdata, output logic err, output int cycles);
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        pstrb[d]   = strb;
        pprot[d]   = prot;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        paddr[d]   = $urandom;
        pwdata[d]  = $urandom;
        pstrb[d]   = 4'($urandom);
        pprot[d]   = 3'($urandom);
        cycles     = 2;
        while (pready[d] !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("pready_seen", {31'b0, pready[d]}, 32'd1);
        rdata = prdata[d];
        err   = pslverr[d];
        @(posedge clk); #1;
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        checkOutput("flags_clear_after_done", {30'b0, pready[d], pslverr[d]}, 32'd0);
        checkOutput("prdata_clear_after_done", prdata[d], 32'd0);
    endtask

    task automatic resetDut(input int d);
        presetn[d] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        presetn[d] = 1'b1;
        checkOutput("reset_prdata", prdata[d], 32'd0);
        checkOutput("reset_flags", {30'b0, pready[d], pslverr[d]}, 32'd0);
        for (int i = 0; i < 16; i++) model_mem[d][i] = 32'd0;
    endtask

    function automatic bit expErr(input bit wr, input logic [31:0] addr, input logic [2:0] prot);
        bit e;
        e = (addr % 4 != 0) || (addr >= 64);
        if (PROT_EN && wr && prot[1] && addr >= 32) e = 1'b1;
        return e;
    endfunction

    task automatic modelXfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] strb, input logic [2:0] prot);
        logic [31:0] rdata, exp_rdata, word;
        logic        err;
        bit          exp_e;
        int          cycles;
        exp_e     = expErr(wr, addr, prot);
        exp_rdata = (wr || exp_e) ? 32'd0 : model_mem[d][addr / 4];
        applyStimulus(d, wr, addr, wdata, strb, prot, rdata, err, cycles);
        checkOutput("rand_prdata", rdata, exp_rdata);
        checkOutput("rand_pslverr", {31'b0, err}, {31'b0, exp_e});
        checkOutput("rand_cycles", 32'(cycles), 32'(waitOf(d) + 2));
        if (wr && !exp_e) begin
            word = model_mem[d][addr / 4];
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) word[8*b +: 8] = wdata[8*b +: 8];
            end
            model_mem[d][addr / 4] = word;
        end
    endtask

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          cycles;
        int          sel;
        logic [31:0] addr;

        num_compared = 0;
        num_failed   = 0;
        for (int d = 0; d < N_DUT; d++) begin
            presetn[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; pprot[d] = '0;
        end
        fork
            resetDut(0);
            resetDut(1);
        join

        vectors.push_back('{1'b0, 32'h08, 32'h0,        4'h0, 3'b000, 32'h0,        1'b0});
        vectors.push_back('{1'b1, 32'h04, 32'hAABBCCDD, 4'hF, 3'b000, 32'h0,        1'b0});
        vectors.push_back('{1'b1, 32'h04, 32'h11223344, 4'h5, 3'b000, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h04, 32'h0,        4'h0, 3'b000, 32'hAA22CC44, 1'b0});
        vectors.push_back('{1'b0, 32'h40, 32'h0,        4'h0, 3'b000, 32'h0,        1'b1});
        vectors.push_back('{1'b1, 32'h06, 32'hDEADBEEF, 4'hF, 3'b000, 32'h0,        1'b1});
        vectors.push_back('{1'b0, 32'h04, 32'h0,        4'hA, 3'b000, 32'hAA22CC44, 1'b0});
        vectors.push_back('{1'b1, 32'h3C, 32'h12345678, 4'h8, 3'b000, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h3C, 32'h0,        4'h0, 3'b000, 32'h12000000, 1'b0});
        vectors.push_back('{1'b0, 32'h3D, 32'h0,        4'h0, 3'b000, 32'h0,        1'b1});
        vectors.push_back('{1'b1, 32'h20, 32'h00000055, 4'hF, 3'b010, 32'h0,        PROT_EN});
        vectors.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 3'b000, PROT_EN ? 32'h0 : 32'h55, 1'b0});
        vectors.push_back('{1'b1, 32'h20, 32'h00000055, 4'hF, 3'b000, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h20, 32'h0,        4'h0, 3'b010, 32'h00000055, 1'b0});
        vectors.push_back('{1'b1, 32'h1C, 32'h00000077, 4'hF, 3'b010, 32'h0,        1'b0});
        vectors.push_back('{1'b0, 32'h1C, 32'h0,        4'h0, 3'b010, 32'h00000077, 1'b0});

        foreach (vectors[i]) begin
            applyStimulus(0, vectors[i].wr, vectors[i].addr, vectors[i].wdata, vectors[i].strb,
                          vectors[i].prot, rdata, err, cycles);
            checkOutput($sformatf("vec%0d_prdata", i), rdata, vectors[i].exp_rdata);
            checkOutput($sformatf("vec%0d_pslverr", i), {31'b0, err}, {31'b0, vectors[i].exp_err});
            checkOutput($sformatf("vec%0d_cycles", i), 32'(cycles), 32'd2);
        end

        // Three wait states: five cycles per transfer, write then read of word 0.
        applyStimulus(1, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 3'b000, rdata, err, cycles);
        checkOutput("ws3_write_cycles", 32'(cycles), 32'd5);
        checkOutput("ws3_write_err", {31'b0, err}, 32'd0);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000, rdata, err, cycles);
        checkOutput("ws3_read_cycles", 32'(cycles), 32'd5);
        checkOutput("ws3_read_data", rdata, 32'hCAFEF00D);

        // Abort: PSEL dropped during a write's access phase leaves the word untouched.
        applyStimulus(1, 1'b1, 32'h8, 32'h0000ABCD, 4'hF, 3'b000, rdata, err, cycles);
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
        paddr[1] = 32'h8; pwdata[1] = 32'hFFFFFFFF; pstrb[1] = 4'hF;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_pready_before", {31'b0, pready[1]}, 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort_pready_after", {31'b0, pready[1]}, 32'd0);
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rdata, err, cycles);
        checkOutput("abort_readback", rdata, 32'h0000ABCD);
        checkOutput("abort_next_cycles", 32'(cycles), 32'd5);

        // Reset mid-access clears outputs on that edge and wipes the memory.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 32'h8;
        @(posedge clk); #1;
        penable[1] = 1'b1;
        @(posedge clk); #1;
        presetn[1] = 1'b0;
        @(posedge clk); #1;
        checkOutput("midreset_pready", {31'b0, pready[1]}, 32'd0);
        checkOutput("midreset_prdata", prdata[1], 32'd0);
        psel[1] = 1'b0; penable[1] = 1'b0; presetn[1] = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, rdata, err, cycles);
        checkOutput("midreset_readback", rdata, 32'h0);
        checkOutput("midreset_cycles", 32'(cycles), 32'd5);

        // Randomized traffic against the array model, starting from cleared memories.
        fork
            resetDut(0);
            resetDut(1);
        join
        for (int d = 0; d < N_DUT; d++) begin
            for (int n = 0; n < 150; n++) begin
                sel = $urandom_range(0, 9);
                if (sel < 7)       addr = 32'($urandom_range(0, 15)) * 4;
                else if (sel == 7) addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
                else if (sel == 8) addr = 32'd64 + 32'($urandom_range(0, 255)) * 4;
                else               addr = 32'hFFFF_FFFC;
                modelXfer(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom), 3'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_failed);
        $finish;
    end

endmodule
